// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between the CPU datapath
// and a DMA/debug requester, with wait-state support and a timeout abort.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err,
  input  logic              err_clear
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state_q, state_d;
  logic               start_c, finish_c, abort_c, pick_dma_c;
  logic               gnt_dma_q, last_dma_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rd_val_c;

  // The control unit gates PC/RegWrite on this while a CPU access is outstanding.
  assign cpu_stall = cpu_req & ~cpu_done;
  assign rd_val_c  = abort_c ? {DATA_W{1'b1}} : mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    finish_c   = 1'b0;
    abort_c    = 1'b0;
    pick_dma_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          start_c    = 1'b1;
          // On a tie the requester that did not win last time goes first.
          pick_dma_c = dma_req && (!cpu_req || !last_dma_q);
          state_d    = BUS;
        end
      end
      BUS: begin
        if (mem_ready) begin
          finish_c = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish_c = 1'b1;
          abort_c  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus latch, wait counter, completion pulses and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b1;
      cnt_q       <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      cpu_done    <= 1'b0;
      dma_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cpu_done <= finish_c & ~gnt_dma_q;
      dma_done <= finish_c & gnt_dma_q;

      if (start_c) begin
        gnt_dma_q  <= pick_dma_c;
        last_dma_q <= pick_dma_c;
        cnt_q      <= '0;
        mem_valid  <= 1'b1;
        mem_we     <= pick_dma_c ? dma_we    : cpu_we;
        mem_addr   <= pick_dma_c ? dma_addr  : cpu_addr;
        mem_wdata  <= pick_dma_c ? dma_wdata : cpu_wdata;
      end else if (finish_c) begin
        mem_valid <= 1'b0;
      end else if (state_q == BUS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (finish_c && !mem_we) begin
        if (gnt_dma_q) dma_rdata <= rd_val_c;
        else           cpu_rdata <= rd_val_c;
      end

      if (abort_c)        timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a scoreboard of expected completions is
// filled as requests are driven and drained as done pulses appear.
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata;
  logic       cpu_done, cpu_stall, dma_done;
  logic       mem_valid, mem_we, mem_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       timeout_err, err_clear;

  typedef struct packed {
    logic       dma;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_cpu_rd, m_dma_rd;
  int         n_assert, n_fail;
  int         cyc, nv;

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ 8'h4A;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic dma, input logic [7:0] addr);
    exp_t e;
    e.dma   = dma;
    e.rdata = addr ^ 8'h4A;
    if (dma) m_dma_rd = e.rdata;
    else     m_cpu_rd = e.rdata;
    sb.push_back(e);
  endtask

  task automatic push_abort_rd(input logic dma);
    exp_t e;
    e.dma   = dma;
    e.rdata = 8'hFF;
    if (dma) m_dma_rd = 8'hFF;
    else     m_cpu_rd = 8'hFF;
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic dma);
    exp_t e;
    e.dma   = dma;
    e.rdata = dma ? m_dma_rd : m_cpu_rd;
    sb.push_back(e);
  endtask

  task automatic check_done();
    exp_t e;
    chk("single_done", 32'(cpu_done & dma_done), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_unexpected_done", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("done_id", 32'({dma_done, cpu_done}), e.dma ? 32'd2 : 32'd1);
      chk("rdata", 32'(e.dma ? dma_rdata : cpu_rdata), 32'(e.rdata));
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(cpu_done || dma_done) && cycles < budget);
    if (!(cpu_done || dma_done)) chk("done_timeout", 32'd0, 32'd1);
    else                         check_done();
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    sb.delete();
    m_cpu_rd = 8'h00;
    m_dma_rd = 8'h00;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ready = 1; err_clear = 0;
    apply_reset();
    tick(); tick();

    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("rst_done", 32'({cpu_done, dma_done}), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // Zero-wait CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    push_rd(1'b0, 8'h10);
    tick();
    chk("t1_valid", 32'(mem_valid), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h10);
    chk("t1_we", 32'(mem_we), 32'd0);
    chk("t1_stall", 32'(cpu_stall), 32'd1);
    tick();
    check_done();
    chk("t1_rdata_5a", 32'(cpu_rdata), 32'h5A);
    chk("t1_stall_done", 32'(cpu_stall), 32'd0);
    chk("t1_valid_resp", 32'(mem_valid), 32'd0);
    cpu_req = 0;
    tick();
    chk("t1_done_pulse", 32'(cpu_done), 32'd0);

    // Both requesters held from reset: CPU, DMA, CPU, DMA
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
    dma_req = 1; dma_we = 0; dma_addr = 8'h42;
    push_rd(1'b0, 8'h21); push_rd(1'b1, 8'h42);
    push_rd(1'b0, 8'h21); push_rd(1'b1, 8'h42);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(10, cyc);
      chk("t2_latency", 32'(cyc), 32'd2);
      if (i == 3) begin
        cpu_req = 0; dma_req = 0;
      end
      tick();
      chk("t2_done_pulse", 32'({cpu_done, dma_done}), 32'd0);
    end

    // DMA read with three wait states
    dma_req = 1; dma_we = 0; dma_addr = 8'h33; mem_ready = 0;
    push_rd(1'b1, 8'h33);
    nv = 0; cyc = 0;
    while (!(cpu_done || dma_done) && cyc < 30) begin
      tick();
      cyc++;
      if (mem_valid) begin
        nv++;
        chk("t3_addr_stable", 32'(mem_addr), 32'h33);
        if (nv == 4) mem_ready = 1;
      end
    end
    if (!(cpu_done || dma_done)) chk("t3_done_timeout", 32'd0, 32'd1);
    else                         check_done();
    chk("t3_valid_cycles", 32'(nv), 32'd4);
    chk("t3_timeout_err", 32'(timeout_err), 32'd0);
    dma_req = 0;
    tick();

    // CPU read against a stuck target: abort after 15 BUS cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h44; mem_ready = 0;
    push_abort_rd(1'b0);
    nv = 0; cyc = 0;
    while (!(cpu_done || dma_done) && cyc < 40) begin
      tick();
      cyc++;
      if (mem_valid) nv++;
    end
    if (!(cpu_done || dma_done)) chk("t4_done_timeout", 32'd0, 32'd1);
    else                         check_done();
    chk("t4_valid_cycles", 32'(nv), 32'd15);
    chk("t4_err_set", 32'(timeout_err), 32'd1);
    cpu_req = 0;
    tick(); tick();
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("t4_err_cleared", 32'(timeout_err), 32'd0);
    mem_ready = 1;

    // DMA write, with a CPU read queued behind it
    dma_req = 1; dma_we = 1; dma_addr = 8'h80; dma_wdata = 8'hC3;
    push_wr(1'b1);
    tick();
    chk("t5_valid", 32'(mem_valid), 32'd1);
    chk("t5_we", 32'(mem_we), 32'd1);
    chk("t5_addr", 32'(mem_addr), 32'h80);
    chk("t5_wdata", 32'(mem_wdata), 32'hC3);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h55;
    push_rd(1'b0, 8'h55);
    tick();
    if (!(cpu_done || dma_done)) chk("t5_wr_done_missing", 32'd0, 32'd1);
    else                         check_done();
    chk("t5_dma_rdata_kept", 32'(dma_rdata), 32'h79);
    dma_req = 0; dma_we = 0;
    wait_done(10, cyc);
    cpu_req = 0;
    tick();

    // Reset during BUS, then a tie after release
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h66; mem_ready = 0;
    tick();
    chk("t6_valid_before", 32'(mem_valid), 32'd1);
    #2;
    apply_reset();
    #1;
    chk("t6_valid_async_drop", 32'(mem_valid), 32'd0);
    tick();
    chk("t6_no_done", 32'({cpu_done, dma_done}), 32'd0);
    cpu_addr = 8'h12;
    dma_req = 1; dma_we = 0; dma_addr = 8'h24; mem_ready = 1;
    push_rd(1'b0, 8'h12); push_rd(1'b1, 8'h24);
    tick();
    chk("t6_no_done_in_reset", 32'({cpu_done, dma_done}), 32'd0);
    reset_n = 1'b1;
    wait_done(10, cyc);
    cpu_req = 0;
    wait_done(10, cyc);
    dma_req = 0;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
